// File: rtl/way_decoder_pkg.sv
// Shared cache definitions: associativity, way-index width, op codes and the
// buffered decode entry used by the L2 way-enable decoder.
package way_decoder_pkg;

    localparam int WAYS  = 8;
    localparam int WAY_W = 3;
    localparam int PTR_W = 3;

    typedef logic [1:0]       op_t;
    typedef logic [WAYS-1:0]  way_mask_t;
    typedef logic [WAY_W-1:0] way_idx_t;

    localparam op_t OP_READ      = 2'b00;
    localparam op_t OP_WRITE     = 2'b01;
    localparam op_t OP_INVAL_ALL = 2'b10;
    localparam op_t OP_RSVD      = 2'b11;

    typedef struct packed {
        op_t       op;
        way_mask_t mask;
    } entry_t;

    // Pointer advance that wraps at the configured depth rather than at 2**PTR_W.
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p,
                                                   input logic [PTR_W-1:0] last);
        return (p == last) ? '0 : p + PTR_W'(1);
    endfunction

endpackage

// File: rtl/way_decoder_if.sv
// Request/response bus between the hit/replacement logic, the way decoder and
// the array control; master drives requests, slave is the decoder.
interface way_decoder_if;
    import way_decoder_pkg::*;

    logic      in_valid;
    logic      in_ready;
    way_idx_t  in_way;
    op_t       in_op;
    logic      out_valid;
    logic      out_ready;
    way_mask_t out_way_en;
    op_t       out_op;

    modport master (
        output in_valid, in_way, in_op, out_ready,
        input  in_ready, out_valid, out_way_en, out_op
    );

    modport slave (
        input  in_valid, in_way, in_op, out_ready,
        output in_ready, out_valid, out_way_en, out_op
    );

endinterface

// File: rtl/way_onehot.sv
// Binary way index to one-hot way enable; inverse of the 8-to-1 way encoder.
// Purely combinational, no handshake.
module way_onehot
    import way_decoder_pkg::*;
(
    input  way_idx_t  way_i,
    output way_mask_t mask_o
);

    always_comb begin
        mask_o        = '0;
        mask_o[way_i] = 1'b1;
    end

endmodule

// File: rtl/way_decoder.sv
// Decodes way index + op into a registered way-enable mask behind a small FIFO;
// 1-cycle accept-to-valid latency, in_ready from registered occupancy only.
module way_decoder
    import way_decoder_pkg::*;
#(
    parameter int FIFO_DEPTH = 2,
    parameter int WAYS_P     = WAYS
) (
    input  logic          clk,
    input  logic          rst_n,
    way_decoder_if.slave  bus,
    output logic          err,
    output logic [3:0]    occupancy
);

    if (FIFO_DEPTH < 2 || FIFO_DEPTH > 8) begin : g_bad_depth
        $error("way_decoder: FIFO_DEPTH must be 2..8");
    end
    if (WAYS_P != 8) begin : g_bad_ways
        $error("way_decoder: WAYS is fixed at 8");
    end

    localparam logic [3:0]       DEPTH_C  = 4'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);
    localparam int               MEM_N    = 2 ** PTR_W;

    localparam logic [1:0] ST_EMPTY   = 2'd0;
    localparam logic [1:0] ST_PARTIAL = 2'd1;
    localparam logic [1:0] ST_FULL    = 2'd2;

    // Assertion is immediate; only the release edge is retimed onto clk.
    logic [1:0] rst_sync_q;
    logic       rst_core_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync_q <= 2'b00;
        else        rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_core_n = rst_sync_q[1];

    logic [1:0]       state_q,  state_d;
    logic [3:0]       count_q,  count_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic             err_q,    err_d;
    entry_t           mem_q [MEM_N];

    logic      push, pop;
    logic      in_ready_w, out_valid_w;
    way_mask_t onehot;
    entry_t    entry_d;

    way_onehot u_onehot (
        .way_i  (bus.in_way),
        .mask_o (onehot)
    );

    always_comb begin
        entry_d.op = bus.in_op;
        unique case (bus.in_op)
            OP_READ, OP_WRITE: entry_d.mask = onehot;
            OP_INVAL_ALL:      entry_d.mask = '1;
            default:           entry_d.mask = '0;
        endcase
    end

    assign in_ready_w  = (state_q != ST_FULL);
    assign out_valid_w = (state_q != ST_EMPTY);
    assign push        = bus.in_valid  & in_ready_w;
    assign pop         = bus.out_ready & out_valid_w;

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        err_d    = err_q | (push && bus.in_op == OP_RSVD);

        if (push) wr_ptr_d = ptr_next(wr_ptr_q, LAST_PTR);
        if (pop)  rd_ptr_d = ptr_next(rd_ptr_q, LAST_PTR);

        if (push && !pop)      count_d = count_q + 4'd1;
        else if (pop && !push) count_d = count_q - 4'd1;

        unique case (state_q)
            ST_EMPTY: begin
                if (push) state_d = ST_PARTIAL;
            end
            ST_PARTIAL: begin
                if (push && !pop && count_q == DEPTH_C - 4'd1) state_d = ST_FULL;
                else if (pop && !push && count_q == 4'd1)      state_d = ST_EMPTY;
            end
            ST_FULL: begin
                if (pop) state_d = ST_PARTIAL;
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_core_n) begin
        if (!rst_core_n) begin
            state_q  <= ST_EMPTY;
            count_q  <= 4'd0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            err_q    <= err_d;
        end
    end

    // Storage needs no reset: the read side is masked while EMPTY.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= entry_d;
    end

    assign bus.in_ready   = in_ready_w;
    assign bus.out_valid  = out_valid_w;
    assign bus.out_way_en = out_valid_w ? mem_q[rd_ptr_q].mask : '0;
    assign bus.out_op     = out_valid_w ? mem_q[rd_ptr_q].op   : OP_READ;
    assign err            = err_q;
    assign occupancy      = count_q;

    a_mask_pop: assert property (@(posedge clk) disable iff (!rst_core_n)
        out_valid_w |-> ($countones(bus.out_way_en) == 1 ||
                         $countones(bus.out_way_en) == 8 ||
                         (bus.out_way_en == '0 && bus.out_op == OP_RSVD)));

    a_hold: assert property (@(posedge clk) disable iff (!rst_core_n)
        (out_valid_w && !bus.out_ready) |=> $stable(bus.out_way_en) && $stable(bus.out_op));

    a_bound: assert property (@(posedge clk) disable iff (!rst_core_n)
        count_q <= DEPTH_C);

endmodule

// File: tb/tb_way_decoder.sv
// Directed bench for way_decoder: reset, backpressure, push/pop overlap, op
// decode, sticky error, mid-operation reset and encoder round trip.
module tb_way_decoder;
    import way_decoder_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       err;
    logic [3:0] occupancy;

    way_decoder_if bus ();

    way_decoder #(.FIFO_DEPTH(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .err       (err),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Model of the existing 8-to-1 way encoder.
    function automatic logic [2:0] enc(input logic [7:0] m);
        logic [2:0] r;
        r = '0;
        for (int k = 0; k < 8; k++) if (m[k]) r = 3'(k);
        return r;
    endfunction

    int rx, tx;

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_way    = '0;
        bus.in_op     = OP_READ;
        bus.out_ready = 1'b1;
        step();
        step();
        check("rst_out_valid", 32'(bus.out_valid), 0);
        check("rst_way_en",    32'(bus.out_way_en), 0);
        check("rst_out_op",    32'(bus.out_op), 0);
        check("rst_err",       32'(err), 0);
        check("rst_occ",       32'(occupancy), 0);
        check("rst_in_ready",  32'(bus.in_ready), 1);
        rst_n = 1'b1;
        step(); step(); step();
        check("post_rst_in_ready", 32'(bus.in_ready), 1);

        // Single read, empty buffer: valid one cycle after acceptance.
        bus.in_valid = 1'b1; bus.in_way = 3'd5; bus.in_op = OP_READ;
        step();
        bus.in_valid = 1'b0;
        check("lat_out_valid", 32'(bus.out_valid), 1);
        check("lat_way_en",    32'(bus.out_way_en), 32'h20);
        check("lat_out_op",    32'(bus.out_op), 0);
        step();
        check("lat_drained", 32'(bus.out_valid), 0);
        check("lat_occ",     32'(occupancy), 0);

        // Fill under backpressure, stall one cycle while full, then drain.
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.in_way = 3'd1; bus.in_op = OP_WRITE;
        step();
        bus.in_way = 3'd6; bus.in_op = OP_READ;
        step();
        bus.in_way = 3'd3;
        check("full_occ",      32'(occupancy), 2);
        check("full_in_ready", 32'(bus.in_ready), 0);
        check("full_head",     32'(bus.out_way_en), 32'h02);
        check("full_head_op",  32'(bus.out_op), 32'(OP_WRITE));
        step();
        bus.in_valid = 1'b0;
        check("full_no_push", 32'(occupancy), 2);
        check("full_hold",    32'(bus.out_way_en), 32'h02);
        bus.out_ready = 1'b1;
        step();
        check("drain_second", 32'(bus.out_way_en), 32'h40);
        check("drain_ready",  32'(bus.in_ready), 1);
        check("drain_occ",    32'(occupancy), 1);
        step();
        check("drain_empty", 32'(bus.out_valid), 0);

        // Occupancy 1, then ten overlapping push/pop cycles.
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.in_way = 3'd0; bus.in_op = OP_READ;
        step();
        for (int i = 1; i <= 10; i++) begin
            logic [7:0] e;
            e = 8'h01 << ((i - 1) % 8);
            bus.in_valid = 1'b1; bus.in_way = 3'(i % 8); bus.out_ready = 1'b1;
            check("sim_occ",  32'(occupancy), 1);
            check("sim_mask", 32'(bus.out_way_en), 32'(e));
            step();
        end
        bus.in_valid = 1'b0;
        check("sim_occ_end",  32'(occupancy), 1);
        check("sim_mask_end", 32'(bus.out_way_en), 32'h04);
        step();
        check("sim_drained", 32'(occupancy), 0);

        // Invalidate-all, then a reserved op.
        bus.in_valid = 1'b1; bus.in_way = 3'd3; bus.in_op = OP_INVAL_ALL;
        step();
        check("inv_mask", 32'(bus.out_way_en), 32'hFF);
        check("inv_op",   32'(bus.out_op), 32'(OP_INVAL_ALL));
        check("inv_err",  32'(err), 0);
        bus.in_way = 3'd2; bus.in_op = OP_RSVD;
        step();
        bus.in_valid = 1'b0; bus.in_op = OP_READ;
        check("rsvd_valid", 32'(bus.out_valid), 1);
        check("rsvd_mask",  32'(bus.out_way_en), 0);
        check("rsvd_op",    32'(bus.out_op), 32'(OP_RSVD));
        check("rsvd_err",   32'(err), 1);
        step();
        check("rsvd_drained", 32'(bus.out_valid), 0);
        for (int i = 0; i < 20; i++) begin
            step();
            check("err_sticky", 32'(err), 1);
        end

        // Reset pulse between edges with two entries buffered.
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.in_way = 3'd4;
        step();
        bus.in_way = 3'd5;
        step();
        bus.in_valid = 1'b0;
        check("mid_occ_pre", 32'(occupancy), 2);
        #3 rst_n = 1'b0;
        #1;
        check("mid_out_valid", 32'(bus.out_valid), 0);
        check("mid_occ",       32'(occupancy), 0);
        check("mid_way_en",    32'(bus.out_way_en), 0);
        check("mid_err",       32'(err), 0);
        #2 rst_n = 1'b1;
        step(); step(); step();
        bus.out_ready = 1'b1;
        check("mid_rel_valid", 32'(bus.out_valid), 0);
        step();
        check("mid_no_stale",  32'(bus.out_valid), 0);
        check("mid_no_stale_mask", 32'(bus.out_way_en), 0);

        // Round trip through the encoder model; 24 entries wrap a depth-2 buffer 12 times.
        rx = 0; tx = 0;
        bus.out_ready = 1'b1;
        for (int cyc = 0; cyc < 100 && rx < 24; cyc++) begin
            bus.in_valid = (tx < 24);
            bus.in_way   = 3'(tx % 8);
            bus.in_op    = OP_READ;
            if (bus.out_valid) begin
                check("rt_index",  32'(enc(bus.out_way_en)), 32'(rx % 8));
                check("rt_onehot", 32'($countones(bus.out_way_en)), 1);
                rx++;
            end
            if (bus.in_valid && bus.in_ready) tx++;
            step();
        end
        bus.in_valid = 1'b0;
        check("rt_count", 32'(rx), 24);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
